cci_host_mem_responder: RTL and testbench



---
 rtl/cci_host_mem_pkg.sv | 40 ++++
 rtl/cci_host_mem_responder_fifo.sv | 95 +++++++++
 rtl/cci_host_mem_responder.sv | 211 +++++++++++++++++++++
 tb/tb_cci_host_mem_responder.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cci_host_mem_pkg.sv
// ---------------------------------------------------------------------------
// cci_host_mem_pkg
// Shared widths, queue entry types and helpers for the CCI-style host memory
// responder.
//   LINE_W    : width of one cache line (64 B)
//   MDATA_W   : width of the requester tag echoed in responses
//   TS_W      : width of the free-running timestamp counter
//   IDX_MAX_W : widest memory line index a read entry can carry
//   t_rd_entry: pending read  {line index, tag, accept timestamp}
//   t_wr_entry: pending write ack {tag, accept timestamp}
// ---------------------------------------------------------------------------
package cci_host_mem_pkg;

  localparam int LINE_W    = 512;
  localparam int MDATA_W   = 16;
  localparam int TS_W      = 16;
  localparam int IDX_MAX_W = 32;

  typedef logic [LINE_W-1:0]  t_line;
  typedef logic [MDATA_W-1:0] t_mdata;
  typedef logic [TS_W-1:0]    t_ts;

  typedef struct packed {
    logic [IDX_MAX_W-1:0] addr;
    t_mdata               mdata;
    t_ts                  ts;
  } t_rd_entry;

  typedef struct packed {
    t_mdata mdata;
    t_ts    ts;
  } t_wr_entry;

  // Age of an entry in cycles; modular subtraction makes counter wrap harmless
  // as long as the latency stays well below 2^TS_W.
  function automatic t_ts ts_age(input t_ts now, input t_ts ts);
    return t_ts'(now - ts);
  endfunction

endpackage

// File: rtl/cci_host_mem_responder_fifo.sv
// ---------------------------------------------------------------------------
// mem_rsp_delay_fifo
// Pending-request queue with a minimum-latency release gate. One instance per
// channel. The head entry becomes eligible for release once it has aged at
// least LATENCY cycles and the response stall is low.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (empties queue)
//   i_push          : push request (ignored while full)
//   i_push_entry    : entry to store
//   i_pop           : pop the head (ignored while empty)
//   i_now           : free-running timestamp
//   i_head_ts       : timestamp field of the current head (fed back by owner)
//   i_stall         : blocks head eligibility while high
//   o_head          : current head entry
//   o_head_elig     : head present, old enough and not stalled
//   o_push_ok       : the push this cycle is accepted
//   o_count         : registered occupancy
//   o_full          : occupancy == DEPTH
//   o_alm_full      : occupancy >= DEPTH - SLACK
// ---------------------------------------------------------------------------
module mem_rsp_delay_fifo
  import cci_host_mem_pkg::*;
#(
  parameter type T_ENTRY = t_wr_entry,
  parameter int  DEPTH   = 16,
  parameter int  LATENCY = 4,
  parameter int  SLACK   = 4,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  T_ENTRY           i_push_entry,
  input  logic             i_pop,
  input  logic [TS_W-1:0]  i_now,
  input  logic [TS_W-1:0]  i_head_ts,
  input  logic             i_stall,
  output T_ENTRY           o_head,
  output logic             o_head_elig,
  output logic             o_push_ok,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_alm_full
);

  T_ENTRY           r_store [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_empty;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [TS_W-1:0]  w_age;

  assign w_empty     = (r_count == '0);
  assign o_full      = (r_count == CNT_W'(DEPTH));
  assign o_alm_full  = (r_count >= CNT_W'(DEPTH - SLACK));
  assign w_push_ok   = i_push && !o_full;
  assign w_pop_ok    = i_pop && !w_empty;
  assign o_push_ok   = w_push_ok;
  assign o_count     = r_count;
  assign o_head      = r_store[r_rd_ptr];
  assign w_age       = ts_age(i_now, i_head_ts);
  assign o_head_elig = !w_empty && !i_stall && (w_age >= TS_W'(LATENCY));

  // Entry storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_store[r_wr_ptr] <= i_push_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cci_host_mem_responder.sv
// ---------------------------------------------------------------------------
// cci_host_mem_responder
// Host memory model answering CCI-style c0 (read) and c1 (write) requests
// after a programmable minimum latency, with per-channel almost-full.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   i_c0_req_*          : read request valid / line address / tag
//   o_c0_alm_full       : read queue almost full
//   o_c0_rsp_*          : read response pulse / line data / echoed tag
//   i_c1_req_*          : write request valid / line address / data / tag
//   o_c1_alm_full       : write queue almost full
//   o_c1_rsp_*          : write ack pulse / echoed tag
//   i_rsp_stall         : holds all response issue while high
//   i_bd_*              : backdoor preload write port
//   o_overflow_err      : sticky, a request arrived at a full queue
//   o_addr_err          : sticky, a request address was >= MEM_LINES
// ---------------------------------------------------------------------------
module cci_host_mem_responder
  import cci_host_mem_pkg::*;
#(
  parameter int  ADDR_W        = 42,
  parameter int  MEM_LINES     = 1024,
  parameter int  FIFO_DEPTH    = 16,
  parameter int  ALMFULL_SLACK = 4,
  parameter int  RD_LATENCY    = 8,
  parameter int  WR_LATENCY    = 4,
  localparam int IDX_W         = $clog2(MEM_LINES),
  localparam int CNT_W         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_c0_req_valid,
  input  logic [ADDR_W-1:0]  i_c0_req_addr,
  input  logic [MDATA_W-1:0] i_c0_req_mdata,
  output logic               o_c0_alm_full,
  output logic               o_c0_rsp_valid,
  output logic [LINE_W-1:0]  o_c0_rsp_data,
  output logic [MDATA_W-1:0] o_c0_rsp_mdata,
  input  logic               i_c1_req_valid,
  input  logic [ADDR_W-1:0]  i_c1_req_addr,
  input  logic [LINE_W-1:0]  i_c1_req_data,
  input  logic [MDATA_W-1:0] i_c1_req_mdata,
  output logic               o_c1_alm_full,
  output logic               o_c1_rsp_valid,
  output logic [MDATA_W-1:0] o_c1_rsp_mdata,
  input  logic               i_rsp_stall,
  input  logic               i_bd_wr_en,
  input  logic [IDX_W-1:0]   i_bd_addr,
  input  logic [LINE_W-1:0]  i_bd_wr_data,
  output logic               o_overflow_err,
  output logic               o_addr_err
);

  logic [TS_W-1:0]    r_now;
  logic [LINE_W-1:0]  r_mem [MEM_LINES];
  logic               r_c0_rsp_valid;
  logic [LINE_W-1:0]  r_c0_rsp_data;
  logic [MDATA_W-1:0] r_c0_rsp_mdata;
  logic               r_c1_rsp_valid;
  logic [MDATA_W-1:0] r_c1_rsp_mdata;
  logic               r_overflow_err;
  logic               r_addr_err;

  logic [IDX_W-1:0]   w_c0_idx;
  logic [IDX_W-1:0]   w_c1_idx;
  logic [IDX_W-1:0]   w_rd_pop_idx;
  logic               w_c0_addr_bad;
  logic               w_c1_addr_bad;
  t_rd_entry          w_rd_push_entry;
  t_rd_entry          w_rd_head;
  t_wr_entry          w_wr_push_entry;
  t_wr_entry          w_wr_head;
  logic               w_c0_push_ok;
  logic               w_c1_push_ok;
  logic               w_c1_commit;
  logic               w_c0_full;
  logic               w_c1_full;
  logic               w_c0_pop;
  logic               w_c1_pop;
  logic [CNT_W-1:0]   w_c0_count;
  logic [CNT_W-1:0]   w_c1_count;
  logic               w_unused;

  // Requests outside the array still get serviced at the wrapped index.
  assign w_c0_idx      = i_c0_req_addr[IDX_W-1:0];
  assign w_c1_idx      = i_c1_req_addr[IDX_W-1:0];
  assign w_c0_addr_bad = |i_c0_req_addr[ADDR_W-1:IDX_W];
  assign w_c1_addr_bad = |i_c1_req_addr[ADDR_W-1:IDX_W];
  assign w_rd_pop_idx  = w_rd_head.addr[IDX_W-1:0];

  assign w_rd_push_entry.addr  = IDX_MAX_W'(w_c0_idx);
  assign w_rd_push_entry.mdata = i_c0_req_mdata;
  assign w_rd_push_entry.ts    = r_now;
  assign w_wr_push_entry.mdata = i_c1_req_mdata;
  assign w_wr_push_entry.ts    = r_now;

  // A write reaches memory only when its queue slot is actually taken.
  assign w_c1_commit = w_c1_push_ok && !reset;

  // Index bits above IDX_W and the occupancy counts are not needed here.
  assign w_unused = ^{w_rd_head.addr[IDX_MAX_W-1:IDX_W], w_c0_count, w_c1_count};

  mem_rsp_delay_fifo #(
    .T_ENTRY (t_rd_entry),
    .DEPTH   (FIFO_DEPTH),
    .LATENCY (RD_LATENCY),
    .SLACK   (ALMFULL_SLACK)
  ) u_rd_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (i_c0_req_valid),
    .i_push_entry (w_rd_push_entry),
    .i_pop        (w_c0_pop),
    .i_now        (r_now),
    .i_head_ts    (w_rd_head.ts),
    .i_stall      (i_rsp_stall),
    .o_head       (w_rd_head),
    .o_head_elig  (w_c0_pop),
    .o_push_ok    (w_c0_push_ok),
    .o_count      (w_c0_count),
    .o_full       (w_c0_full),
    .o_alm_full   (o_c0_alm_full)
  );

  mem_rsp_delay_fifo #(
    .T_ENTRY (t_wr_entry),
    .DEPTH   (FIFO_DEPTH),
    .LATENCY (WR_LATENCY),
    .SLACK   (ALMFULL_SLACK)
  ) u_wr_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (i_c1_req_valid),
    .i_push_entry (w_wr_push_entry),
    .i_pop        (w_c1_pop),
    .i_now        (r_now),
    .i_head_ts    (w_wr_head.ts),
    .i_stall      (i_rsp_stall),
    .o_head       (w_wr_head),
    .o_head_elig  (w_c1_pop),
    .o_push_ok    (w_c1_push_ok),
    .o_count      (w_c1_count),
    .o_full       (w_c1_full),
    .o_alm_full   (o_c1_alm_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_now <= '0;
    end else begin
      r_now <= r_now + 1'b1;
    end
  end

  // Memory survives reset. The c1 write is placed last so it overrides a
  // backdoor write to the same line in the same cycle.
  always_ff @(posedge clk) begin
    if (i_bd_wr_en) begin
      r_mem[i_bd_addr] <= i_bd_wr_data;
    end
    if (w_c1_commit) begin
      r_mem[w_c1_idx] <= i_c1_req_data;
    end
  end

  // Read data is sampled from the array before this edge's writes land,
  // giving read-first behaviour on same-cycle index collisions.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_c0_rsp_valid <= 1'b0;
      r_c0_rsp_data  <= '0;
      r_c0_rsp_mdata <= '0;
      r_c1_rsp_valid <= 1'b0;
      r_c1_rsp_mdata <= '0;
    end else begin
      r_c0_rsp_valid <= w_c0_pop;
      r_c1_rsp_valid <= w_c1_pop;
      if (w_c0_pop) begin
        r_c0_rsp_data  <= r_mem[w_rd_pop_idx];
        r_c0_rsp_mdata <= w_rd_head.mdata;
      end
      if (w_c1_pop) begin
        r_c1_rsp_mdata <= w_wr_head.mdata;
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow_err <= 1'b0;
      r_addr_err     <= 1'b0;
    end else begin
      if ((i_c0_req_valid && w_c0_full) || (i_c1_req_valid && w_c1_full)) begin
        r_overflow_err <= 1'b1;
      end
      if ((i_c0_req_valid && w_c0_addr_bad) || (i_c1_req_valid && w_c1_addr_bad)) begin
        r_addr_err <= 1'b1;
      end
    end
  end

  assign o_c0_rsp_valid = r_c0_rsp_valid;
  assign o_c0_rsp_data  = r_c0_rsp_data;
  assign o_c0_rsp_mdata = r_c0_rsp_mdata;
  assign o_c1_rsp_valid = r_c1_rsp_valid;
  assign o_c1_rsp_mdata = r_c1_rsp_mdata;
  assign o_overflow_err = r_overflow_err;
  assign o_addr_err     = r_addr_err;

endmodule

// File: tb/tb_cci_host_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_cci_host_mem_responder
// Self-checking bench for cci_host_mem_responder. Responses are collected by
// a monitor into queues; each test task compares them against expectations
// derived from a line-level memory model with a timestamped write log.
// ---------------------------------------------------------------------------
module tb_cci_host_mem_responder;

  localparam int ADDR_W    = 42;
  localparam int MEM_LINES = 1024;
  localparam int IDX_W     = 10;
  localparam int RD_LAT    = 8;
  localparam int WR_LAT    = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               i_c0_req_valid;
  logic [ADDR_W-1:0]  i_c0_req_addr;
  logic [15:0]        i_c0_req_mdata;
  logic               o_c0_alm_full;
  logic               o_c0_rsp_valid;
  logic [511:0]       o_c0_rsp_data;
  logic [15:0]        o_c0_rsp_mdata;
  logic               i_c1_req_valid;
  logic [ADDR_W-1:0]  i_c1_req_addr;
  logic [511:0]       i_c1_req_data;
  logic [15:0]        i_c1_req_mdata;
  logic               o_c1_alm_full;
  logic               o_c1_rsp_valid;
  logic [15:0]        o_c1_rsp_mdata;
  logic               i_rsp_stall;
  logic               i_bd_wr_en;
  logic [IDX_W-1:0]   i_bd_addr;
  logic [511:0]       i_bd_wr_data;
  logic               o_overflow_err;
  logic               o_addr_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int           c;
    logic [511:0] data;
    logic [15:0]  mdata;
  } rsp_t;

  typedef struct {
    int           c;
    int           idx;
    logic [511:0] data;
  } wlog_t;

  typedef struct {
    int          c;
    int          idx;
    logic [15:0] md;
  } req_t;

  rsp_t         rd_obs[$];
  rsp_t         wr_obs[$];
  wlog_t        wlog[$];
  logic [511:0] mdl_mem [MEM_LINES];

  cci_host_mem_responder dut (
    .clk            (clk),
    .reset          (reset),
    .i_c0_req_valid (i_c0_req_valid),
    .i_c0_req_addr  (i_c0_req_addr),
    .i_c0_req_mdata (i_c0_req_mdata),
    .o_c0_alm_full  (o_c0_alm_full),
    .o_c0_rsp_valid (o_c0_rsp_valid),
    .o_c0_rsp_data  (o_c0_rsp_data),
    .o_c0_rsp_mdata (o_c0_rsp_mdata),
    .i_c1_req_valid (i_c1_req_valid),
    .i_c1_req_addr  (i_c1_req_addr),
    .i_c1_req_data  (i_c1_req_data),
    .i_c1_req_mdata (i_c1_req_mdata),
    .o_c1_alm_full  (o_c1_alm_full),
    .o_c1_rsp_valid (o_c1_rsp_valid),
    .o_c1_rsp_mdata (o_c1_rsp_mdata),
    .i_rsp_stall    (i_rsp_stall),
    .i_bd_wr_en     (i_bd_wr_en),
    .i_bd_addr      (i_bd_addr),
    .i_bd_wr_data   (i_bd_wr_data),
    .o_overflow_err (o_overflow_err),
    .o_addr_err     (o_addr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Responses are sampled mid-cycle and tagged with the cycle they appeared in.
  always @(negedge clk) begin
    rsp_t r;
    if (o_c0_rsp_valid === 1'b1) begin
      r.c = cyc; r.data = o_c0_rsp_data; r.mdata = o_c0_rsp_mdata;
      rd_obs.push_back(r);
    end
    if (o_c1_rsp_valid === 1'b1) begin
      r.c = cyc; r.data = '0; r.mdata = o_c1_rsp_mdata;
      wr_obs.push_back(r);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time exceeded, got no finish, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_c0_req_valid = 1'b0;
    i_c1_req_valid = 1'b0;
    i_bd_wr_en     = 1'b0;
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic log_write(input int c, input int idx, input logic [511:0] d);
    wlog_t e;
    e.c = c; e.idx = idx; e.data = d;
    wlog.push_back(e);
  endtask

  // Line contents as seen by a read popped in cycle c (writes accepted in
  // cycle c itself are not yet visible).
  function automatic logic [511:0] mem_at(input int idx, input int c);
    for (int i = wlog.size() - 1; i >= 0; i--) begin
      if (wlog[i].idx == idx && wlog[i].c < c) return wlog[i].data;
    end
    return mdl_mem[idx];
  endfunction

  task automatic flush_log();
    foreach (wlog[i]) mdl_mem[wlog[i].idx] = wlog[i].data;
    wlog.delete();
    rd_obs.delete();
    wr_obs.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    i_rsp_stall = 1'b0;
    i_c0_req_addr = '0; i_c0_req_mdata = '0;
    i_c1_req_addr = '0; i_c1_req_data = '0; i_c1_req_mdata = '0;
    i_bd_addr = '0; i_bd_wr_data = '0;
    step(3);
    checks++; if (o_c0_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_c0_valid: got %b expected 0", o_c0_rsp_valid); end
    checks++; if (o_c1_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_c1_valid: got %b expected 0", o_c1_rsp_valid); end
    checks++; if ({o_c0_alm_full, o_c1_alm_full} !== 2'b00) begin errors++; $display("[TB] FAIL reset_alm_full: got %b expected 00", {o_c0_alm_full, o_c1_alm_full}); end
    checks++; if ({o_overflow_err, o_addr_err} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 00", {o_overflow_err, o_addr_err}); end
    checks++; if (o_c0_rsp_data !== '0) begin errors++; $display("[TB] FAIL reset_c0_data: got %h expected 0", o_c0_rsp_data); end
    checks++; if ({o_c0_rsp_mdata, o_c1_rsp_mdata} !== 32'h0) begin errors++; $display("[TB] FAIL reset_mdata: got %h expected 0", {o_c0_rsp_mdata, o_c1_rsp_mdata}); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_preload();
    logic [511:0] d;
    for (int i = 0; i < MEM_LINES; i++) begin
      d = rand_line();
      i_bd_wr_en = 1'b1; i_bd_addr = IDX_W'(i); i_bd_wr_data = d;
      mdl_mem[i] = d;
      step();
    end
    i_bd_wr_en = 1'b0;
    step();
  endtask

  task automatic test_basic_read();
    int t0;
    logic [511:0] a5;
    a5 = {64{8'hA5}};
    flush_log();
    i_bd_wr_en = 1'b1; i_bd_addr = 10'd5; i_bd_wr_data = a5;
    log_write(cyc, 5, a5);
    step();
    i_bd_wr_en = 1'b0;
    i_c0_req_valid = 1'b1; i_c0_req_addr = 42'd5; i_c0_req_mdata = 16'h0012;
    t0 = cyc;
    step();
    i_c0_req_valid = 1'b0;
    step(14);
    checks++; if (rd_obs.size() !== 1) begin errors++; $display("[TB] FAIL basic_rd_count: got %0d expected 1", rd_obs.size()); end
    if (rd_obs.size() > 0) begin
      checks++; if (rd_obs[0].c !== t0 + RD_LAT + 1) begin errors++; $display("[TB] FAIL basic_rd_latency: got %0d expected %0d", rd_obs[0].c - t0, RD_LAT + 1); end
      checks++; if (rd_obs[0].data !== a5) begin errors++; $display("[TB] FAIL basic_rd_data: got %h expected %h", rd_obs[0].data, a5); end
      checks++; if (rd_obs[0].mdata !== 16'h0012) begin errors++; $display("[TB] FAIL basic_rd_mdata: got %h expected 0012", rd_obs[0].mdata); end
    end
  endtask

  task automatic test_write_then_read();
    int tw, tr;
    logic [511:0] dd;
    dd = {16{32'hDEADBEEF}};
    flush_log();
    i_c1_req_valid = 1'b1; i_c1_req_addr = 42'd3; i_c1_req_data = dd; i_c1_req_mdata = 16'd7;
    tw = cyc;
    log_write(tw, 3, dd);
    step();
    i_c1_req_valid = 1'b0;
    i_c0_req_valid = 1'b1; i_c0_req_addr = 42'd3; i_c0_req_mdata = 16'h0033;
    tr = cyc;
    step();
    i_c0_req_valid = 1'b0;
    step(14);
    checks++; if (wr_obs.size() !== 1) begin errors++; $display("[TB] FAIL wr_ack_count: got %0d expected 1", wr_obs.size()); end
    if (wr_obs.size() > 0) begin
      checks++; if (wr_obs[0].c !== tw + WR_LAT + 1) begin errors++; $display("[TB] FAIL wr_ack_latency: got %0d expected %0d", wr_obs[0].c - tw, WR_LAT + 1); end
      checks++; if (wr_obs[0].mdata !== 16'd7) begin errors++; $display("[TB] FAIL wr_ack_mdata: got %h expected 0007", wr_obs[0].mdata); end
    end
    checks++; if (rd_obs.size() !== 1) begin errors++; $display("[TB] FAIL raw_rd_count: got %0d expected 1", rd_obs.size()); end
    if (rd_obs.size() > 0) begin
      checks++; if (rd_obs[0].c !== tr + RD_LAT + 1) begin errors++; $display("[TB] FAIL raw_rd_latency: got %0d expected %0d", rd_obs[0].c - tr, RD_LAT + 1); end
      checks++; if (rd_obs[0].data !== dd) begin errors++; $display("[TB] FAIL raw_rd_data: got %h expected %h", rd_obs[0].data, dd); end
    end
  endtask

  task automatic test_random_traffic();
    req_t rd_exp[$];
    req_t wr_exp[$];
    req_t q;
    int idx, e, prev, n;
    logic [511:0] d;
    logic [15:0] md;
    flush_log();
    md = 16'h1000;
    for (int k = 0; k < 300; k++) begin
      idle_inputs();
      if ($urandom_range(0, 9) == 0) begin
        idx = $urandom_range(0, 31); d = rand_line();
        i_bd_wr_en = 1'b1; i_bd_addr = IDX_W'(idx); i_bd_wr_data = d;
        log_write(cyc, idx, d);
      end
      if ($urandom_range(0, 99) < 40 && !o_c0_alm_full) begin
        idx = $urandom_range(0, 31);
        i_c0_req_valid = 1'b1; i_c0_req_addr = ADDR_W'(idx); i_c0_req_mdata = md;
        q.c = cyc; q.idx = idx; q.md = md;
        rd_exp.push_back(q);
        md++;
      end
      if ($urandom_range(0, 99) < 40 && !o_c1_alm_full) begin
        idx = $urandom_range(0, 31); d = rand_line();
        i_c1_req_valid = 1'b1; i_c1_req_addr = ADDR_W'(idx); i_c1_req_data = d; i_c1_req_mdata = md;
        log_write(cyc, idx, d);
        q.c = cyc; q.idx = idx; q.md = md;
        wr_exp.push_back(q);
        md++;
      end
      step();
    end
    idle_inputs();
    step(40);
    checks++; if (rd_obs.size() !== rd_exp.size()) begin errors++; $display("[TB] FAIL rand_rd_count: got %0d expected %0d", rd_obs.size(), rd_exp.size()); end
    checks++; if (wr_obs.size() !== wr_exp.size()) begin errors++; $display("[TB] FAIL rand_wr_count: got %0d expected %0d", wr_obs.size(), wr_exp.size()); end
    n = (rd_obs.size() < rd_exp.size()) ? rd_obs.size() : rd_exp.size();
    prev = -1;
    for (int i = 0; i < n; i++) begin
      e = rd_exp[i].c + RD_LAT + 1;
      if (e <= prev) e = prev + 1;
      prev = e;
      checks++; if (rd_obs[i].c !== e) begin errors++; $display("[TB] FAIL rand_rd_cycle[%0d]: got %0d expected %0d", i, rd_obs[i].c, e); end
      checks++; if (rd_obs[i].mdata !== rd_exp[i].md) begin errors++; $display("[TB] FAIL rand_rd_mdata[%0d]: got %h expected %h", i, rd_obs[i].mdata, rd_exp[i].md); end
      checks++; if (rd_obs[i].data !== mem_at(rd_exp[i].idx, e - 1)) begin errors++; $display("[TB] FAIL rand_rd_data[%0d]: got %h expected %h", i, rd_obs[i].data, mem_at(rd_exp[i].idx, e - 1)); end
    end
    n = (wr_obs.size() < wr_exp.size()) ? wr_obs.size() : wr_exp.size();
    prev = -1;
    for (int i = 0; i < n; i++) begin
      e = wr_exp[i].c + WR_LAT + 1;
      if (e <= prev) e = prev + 1;
      prev = e;
      checks++; if (wr_obs[i].c !== e) begin errors++; $display("[TB] FAIL rand_wr_cycle[%0d]: got %0d expected %0d", i, wr_obs[i].c, e); end
      checks++; if (wr_obs[i].mdata !== wr_exp[i].md) begin errors++; $display("[TB] FAIL rand_wr_mdata[%0d]: got %h expected %h", i, wr_obs[i].mdata, wr_exp[i].md); end
    end
    checks++; if ({o_overflow_err, o_addr_err} !== 2'b00) begin errors++; $display("[TB] FAIL rand_flags: got %b expected 00", {o_overflow_err, o_addr_err}); end
  endtask

  task automatic test_stall_almfull();
    int idxs[12];
    int r;
    flush_log();
    i_rsp_stall = 1'b1;
    for (int i = 0; i < 12; i++) begin
      idxs[i] = $urandom_range(0, MEM_LINES - 1);
      i_c0_req_valid = 1'b1; i_c0_req_addr = ADDR_W'(idxs[i]); i_c0_req_mdata = 16'(i);
      step();
      if (i == 10) begin
        checks++; if (o_c0_alm_full !== 1'b0) begin errors++; $display("[TB] FAIL alm_full_at_11: got %b expected 0", o_c0_alm_full); end
      end
      if (i == 11) begin
        checks++; if (o_c0_alm_full !== 1'b1) begin errors++; $display("[TB] FAIL alm_full_at_12: got %b expected 1", o_c0_alm_full); end
      end
    end
    i_c0_req_valid = 1'b0;
    step(12);
    checks++; if (rd_obs.size() !== 0) begin errors++; $display("[TB] FAIL stall_holds: got %0d responses expected 0", rd_obs.size()); end
    i_rsp_stall = 1'b0;
    r = cyc;
    checks++; if (o_c0_alm_full !== 1'b1) begin errors++; $display("[TB] FAIL alm_full_before_pop: got %b expected 1", o_c0_alm_full); end
    step();
    checks++; if (o_c0_alm_full !== 1'b0) begin errors++; $display("[TB] FAIL alm_full_after_pop: got %b expected 0", o_c0_alm_full); end
    step(20);
    checks++; if (rd_obs.size() !== 12) begin errors++; $display("[TB] FAIL stall_rsp_count: got %0d expected 12", rd_obs.size()); end
    for (int i = 0; i < 12 && i < rd_obs.size(); i++) begin
      checks++; if (rd_obs[i].c !== r + 1 + i) begin errors++; $display("[TB] FAIL stall_rsp_cycle[%0d]: got %0d expected %0d", i, rd_obs[i].c, r + 1 + i); end
      checks++; if (rd_obs[i].mdata !== 16'(i)) begin errors++; $display("[TB] FAIL stall_rsp_mdata[%0d]: got %h expected %h", i, rd_obs[i].mdata, 16'(i)); end
      checks++; if (rd_obs[i].data !== mdl_mem[idxs[i]]) begin errors++; $display("[TB] FAIL stall_rsp_data[%0d]: got %h expected %h", i, rd_obs[i].data, mdl_mem[idxs[i]]); end
    end
  endtask

  task automatic test_overflow();
    int idxs[17];
    flush_log();
    i_rsp_stall = 1'b1;
    for (int i = 0; i < 17; i++) begin
      idxs[i] = $urandom_range(0, MEM_LINES - 1);
      i_c0_req_valid = 1'b1; i_c0_req_addr = ADDR_W'(idxs[i]); i_c0_req_mdata = 16'(16'h0100 + i);
      step();
    end
    i_c0_req_valid = 1'b0;
    checks++; if (o_overflow_err !== 1'b1) begin errors++; $display("[TB] FAIL overflow_set: got %b expected 1", o_overflow_err); end
    step(10);
    i_rsp_stall = 1'b0;
    step(30);
    checks++; if (rd_obs.size() !== 16) begin errors++; $display("[TB] FAIL overflow_rsp_count: got %0d expected 16", rd_obs.size()); end
    for (int i = 0; i < 16 && i < rd_obs.size(); i++) begin
      checks++; if (rd_obs[i].mdata !== 16'(16'h0100 + i)) begin errors++; $display("[TB] FAIL overflow_rsp_mdata[%0d]: got %h expected %h", i, rd_obs[i].mdata, 16'(16'h0100 + i)); end
      checks++; if (rd_obs[i].data !== mdl_mem[idxs[i]]) begin errors++; $display("[TB] FAIL overflow_rsp_data[%0d]: got %h expected %h", i, rd_obs[i].data, mdl_mem[idxs[i]]); end
    end
    checks++; if (o_overflow_err !== 1'b1) begin errors++; $display("[TB] FAIL overflow_sticky: got %b expected 1", o_overflow_err); end
  endtask

  task automatic test_addr_err();
    int t0;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    flush_log();
    checks++; if ({o_overflow_err, o_addr_err} !== 2'b00) begin errors++; $display("[TB] FAIL flags_cleared: got %b expected 00", {o_overflow_err, o_addr_err}); end
    i_c0_req_valid = 1'b1; i_c0_req_addr = ADDR_W'(MEM_LINES + 2); i_c0_req_mdata = 16'h0055;
    t0 = cyc;
    step();
    i_c0_req_valid = 1'b0;
    checks++; if (o_addr_err !== 1'b1) begin errors++; $display("[TB] FAIL addr_err_set: got %b expected 1", o_addr_err); end
    step(12);
    checks++; if (rd_obs.size() !== 1) begin errors++; $display("[TB] FAIL addr_err_rsp_count: got %0d expected 1", rd_obs.size()); end
    if (rd_obs.size() > 0) begin
      checks++; if (rd_obs[0].data !== mdl_mem[2]) begin errors++; $display("[TB] FAIL addr_err_wrap_data: got %h expected %h", rd_obs[0].data, mdl_mem[2]); end
      checks++; if (rd_obs[0].c !== t0 + RD_LAT + 1) begin errors++; $display("[TB] FAIL addr_err_latency: got %0d expected %0d", rd_obs[0].c - t0, RD_LAT + 1); end
    end
  endtask

  task automatic test_reset_mid();
    logic [511:0] d;
    flush_log();
    d = rand_line();
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      i_c0_req_valid = 1'b1;
      i_c0_req_addr  = (i == 2) ? ADDR_W'(MEM_LINES + 7) : ADDR_W'(i + 50);
      i_c0_req_mdata = 16'(16'h0200 + i);
      if (i == 1) begin
        i_c1_req_valid = 1'b1; i_c1_req_addr = 42'd40; i_c1_req_data = d; i_c1_req_mdata = 16'h0299;
        log_write(cyc, 40, d);
      end
      step();
    end
    idle_inputs();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(20);
    checks++; if (rd_obs.size() !== 0) begin errors++; $display("[TB] FAIL reset_mid_rd_rsp: got %0d expected 0", rd_obs.size()); end
    checks++; if (wr_obs.size() !== 0) begin errors++; $display("[TB] FAIL reset_mid_wr_rsp: got %0d expected 0", wr_obs.size()); end
    checks++; if ({o_overflow_err, o_addr_err, o_c0_alm_full, o_c1_alm_full} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_mid_flags: got %b expected 0000", {o_overflow_err, o_addr_err, o_c0_alm_full, o_c1_alm_full}); end
    flush_log();
    i_c0_req_valid = 1'b1; i_c0_req_addr = 42'd40; i_c0_req_mdata = 16'h02AA;
    step();
    i_c0_req_valid = 1'b0;
    step(12);
    checks++; if (rd_obs.size() !== 1) begin errors++; $display("[TB] FAIL committed_rd_count: got %0d expected 1", rd_obs.size()); end
    if (rd_obs.size() > 0) begin
      checks++; if (rd_obs[0].data !== d) begin errors++; $display("[TB] FAIL committed_write_kept: got %h expected %h", rd_obs[0].data, d); end
    end
  endtask

  task automatic test_hazard();
    int a;
    logic [511:0] old9, new9, bdv;
    flush_log();
    old9 = mdl_mem[9];
    new9 = ~old9;
    bdv  = rand_line();
    i_c0_req_valid = 1'b1; i_c0_req_addr = 42'd9; i_c0_req_mdata = 16'h0300;
    a = cyc;
    step();
    i_c0_req_valid = 1'b0;
    step(RD_LAT - 1);
    // The read of line 9 pops at the end of this cycle.
    i_bd_wr_en = 1'b1; i_bd_addr = 10'd9; i_bd_wr_data = bdv;
    log_write(cyc, 9, bdv);
    i_c1_req_valid = 1'b1; i_c1_req_addr = 42'd9; i_c1_req_data = new9; i_c1_req_mdata = 16'h0301;
    log_write(cyc, 9, new9);
    step();
    idle_inputs();
    step(12);
    i_c0_req_valid = 1'b1; i_c0_req_addr = 42'd9; i_c0_req_mdata = 16'h0302;
    step();
    i_c0_req_valid = 1'b0;
    step(12);
    checks++; if (rd_obs.size() !== 2) begin errors++; $display("[TB] FAIL hazard_rd_count: got %0d expected 2", rd_obs.size()); end
    if (rd_obs.size() > 1) begin
      checks++; if (rd_obs[0].c !== a + RD_LAT + 1) begin errors++; $display("[TB] FAIL hazard_pop_cycle: got %0d expected %0d", rd_obs[0].c, a + RD_LAT + 1); end
      checks++; if (rd_obs[0].data !== old9) begin errors++; $display("[TB] FAIL hazard_read_first: got %h expected %h", rd_obs[0].data, old9); end
      checks++; if (rd_obs[1].data !== new9) begin errors++; $display("[TB] FAIL hazard_c1_wins: got %h expected %h", rd_obs[1].data, new9); end
    end
    checks++; if (wr_obs.size() !== 1) begin errors++; $display("[TB] FAIL hazard_wr_ack: got %0d expected 1", wr_obs.size()); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    i_rsp_stall = 1'b0;
    test_reset();
    test_preload();
    test_basic_read();
    test_write_then_read();
    test_random_traffic();
    test_stall_almfull();
    test_overflow();
    test_addr_err();
    test_reset_mid();
    test_hazard();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
